// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared types and constants for the PDP-8 memory arbiter
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
package pdp8_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_EXEC_RD, OWN_EXEC_WR} arb_owner_e;
  localparam int ARB_LAT_W = 3;
endpackage

// File: rtl/pdp_arb_pick.sv
// pdp_arb_pick: picks the next memory owner; PDP_MEM_ARB_RR_EN alternates exec/IFU on ties
module pdp_arb_pick
  import pdp8_pkg::*;
(
  input  logic       ifu_req,
  input  logic       exec_rd_req,
  input  logic       exec_wr_req,
  input  logic       last_exec,
  output arb_owner_e owner
);
  logic exec_first;
`ifdef PDP_MEM_ARB_RR_EN
  assign exec_first = !(ifu_req && last_exec);
`else
  logic unused_last;
  assign unused_last = last_exec;
  assign exec_first = 1'b1;
`endif
  assign owner = (exec_wr_req || exec_rd_req) && exec_first ? (exec_wr_req ? OWN_EXEC_WR : OWN_EXEC_RD) :
                 ifu_req ? OWN_IFU : OWN_NONE;
endmodule

// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter: shares one single-port memory between IFU and exec; PDP_MEM_ARB_RR_EN enables round-robin ties
module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_W     = `ADDR_WIDTH,
  parameter int DATA_W     = `DATA_WIDTH,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ifu_rd_req,
  input  logic [ADDR_W-1:0] ifu_rd_addr,
  output logic              ifu_gnt,
  output logic              ifu_rd_valid,
  output logic [DATA_W-1:0] ifu_rd_data,
  input  logic              exec_rd_req,
  input  logic [ADDR_W-1:0] exec_rd_addr,
  input  logic              exec_wr_req,
  input  logic [ADDR_W-1:0] exec_wr_addr,
  input  logic [DATA_W-1:0] exec_wr_data,
  output logic              exec_gnt,
  output logic              exec_rd_valid,
  output logic [DATA_W-1:0] exec_rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d, pick;
  logic [ARB_LAT_W-1:0] cnt_q, cnt_d;
  logic last_exec_q, last_exec_d;
  logic ifu_gnt_q, ifu_gnt_d, exec_gnt_q, exec_gnt_d;
  logic ifu_rd_valid_q, ifu_rd_valid_d, exec_rd_valid_q, exec_rd_valid_d;
  logic [DATA_W-1:0] ifu_rd_data_q, ifu_rd_data_d, exec_rd_data_q, exec_rd_data_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  pdp_arb_pick u_pick (
    .ifu_req     (ifu_rd_req),
    .exec_rd_req (exec_rd_req),
    .exec_wr_req (exec_wr_req),
    .last_exec   (last_exec_q),
    .owner       (pick)
  );

  // Next state and registered outputs; the mem_* registers double as the command latch
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    last_exec_d = last_exec_q;
    ifu_gnt_d = 1'b0;
    exec_gnt_d = 1'b0;
    ifu_rd_valid_d = 1'b0;
    exec_rd_valid_d = 1'b0;
    ifu_rd_data_d = ifu_rd_data_q;
    exec_rd_data_d = exec_rd_data_q;
    mem_req_d = 1'b0;
    mem_we_d = 1'b0;
    mem_addr_d = '0;
    mem_wdata_d = '0;
    case (state_q)
      IDLE: if (pick != OWN_NONE) begin
        state_d = CMD;
        owner_d = pick;
        last_exec_d = pick != OWN_IFU;
        ifu_gnt_d = pick == OWN_IFU;
        exec_gnt_d = pick != OWN_IFU;
        mem_req_d = 1'b1;
        mem_we_d = pick == OWN_EXEC_WR;
        mem_addr_d = pick == OWN_IFU ? ifu_rd_addr : pick == OWN_EXEC_RD ? exec_rd_addr : exec_wr_addr;
        mem_wdata_d = pick == OWN_EXEC_WR ? exec_wr_data : '0;
      end
      CMD: begin
        state_d = owner_q == OWN_EXEC_WR ? IDLE : WAIT;
        cnt_d = ARB_LAT_W'(MEM_RD_LAT);
      end
      WAIT: begin
        cnt_d = cnt_q - ARB_LAT_W'(1);
        if (cnt_q == ARB_LAT_W'(1)) begin
          state_d = RESP;
          ifu_rd_valid_d = owner_q == OWN_IFU;
          exec_rd_valid_d = owner_q == OWN_EXEC_RD;
          ifu_rd_data_d = owner_q == OWN_IFU ? mem_rdata : ifu_rd_data_q;
          exec_rd_data_d = owner_q == OWN_EXEC_RD ? mem_rdata : exec_rd_data_q;
        end
      end
      RESP: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  // State and output registers; reset drops any in-flight read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      cnt_q <= '0;
      last_exec_q <= 1'b0;
      ifu_gnt_q <= 1'b0;
      exec_gnt_q <= 1'b0;
      ifu_rd_valid_q <= 1'b0;
      exec_rd_valid_q <= 1'b0;
      ifu_rd_data_q <= '0;
      exec_rd_data_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      last_exec_q <= last_exec_d;
      ifu_gnt_q <= ifu_gnt_d;
      exec_gnt_q <= exec_gnt_d;
      ifu_rd_valid_q <= ifu_rd_valid_d;
      exec_rd_valid_q <= exec_rd_valid_d;
      ifu_rd_data_q <= ifu_rd_data_d;
      exec_rd_data_q <= exec_rd_data_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q <= busy_d;
    end
  end

  assign ifu_gnt = ifu_gnt_q;
  assign exec_gnt = exec_gnt_q;
  assign ifu_rd_valid = ifu_rd_valid_q;
  assign exec_rd_valid = exec_rd_valid_q;
  assign ifu_rd_data = ifu_rd_data_q;
  assign exec_rd_data = exec_rd_data_q;
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb_pdp_mem_arbiter: scoreboard bench for pdp_mem_arbiter, three instances at read latencies 1, 3 and 7
module tb_pdp_mem_arbiter;
`ifdef PDP_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [11:0] ifu_q[$];
  logic [11:0] exec_q[$];
  int glog[$];

  logic ifu_rd_req [3];
  logic [11:0] ifu_rd_addr [3];
  logic ifu_gnt [3];
  logic ifu_rd_valid [3];
  logic [11:0] ifu_rd_data [3];
  logic exec_rd_req [3];
  logic [11:0] exec_rd_addr [3];
  logic exec_wr_req [3];
  logic [11:0] exec_wr_addr [3];
  logic [11:0] exec_wr_data [3];
  logic exec_gnt [3];
  logic exec_rd_valid [3];
  logic [11:0] exec_rd_data [3];
  logic mem_req [3];
  logic mem_we [3];
  logic [11:0] mem_addr [3];
  logic [11:0] mem_wdata [3];
  logic [11:0] mem_rdata [3];
  logic busy [3];

  always #5 clk = ~clk;

  // Cycle counter used to time grants and valid pulses
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int g);
    return g == 0 ? 1 : g == 1 ? 3 : 7;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gm
    localparam int L = g == 0 ? 1 : g == 1 ? 3 : 7;
    logic [11:0] mem [int];
    logic [11:0] pd [7];
    logic [6:0] pv = '0;
    // Read pipeline: data is valid L cycles after the mem_req cycle; unwritten words read as ~addr
    always @(posedge clk) begin
      pd[0] <= mem.exists(int'(mem_addr[g])) ? mem[int'(mem_addr[g])] : ~mem_addr[g];
      pv <= {pv[5:0], mem_req[g] && !mem_we[g]};
      for (int j = 1; j < 7; j++) pd[j] <= pd[j-1];
    end
    // Memory writes
    always @(posedge clk) if (mem_req[g] && mem_we[g]) mem[int'(mem_addr[g])] = mem_wdata[g];
    assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 12'o0;
    pdp_mem_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_RD_LAT(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .ifu_rd_req(ifu_rd_req[g]), .ifu_rd_addr(ifu_rd_addr[g]), .ifu_gnt(ifu_gnt[g]),
      .ifu_rd_valid(ifu_rd_valid[g]), .ifu_rd_data(ifu_rd_data[g]),
      .exec_rd_req(exec_rd_req[g]), .exec_rd_addr(exec_rd_addr[g]),
      .exec_wr_req(exec_wr_req[g]), .exec_wr_addr(exec_wr_addr[g]), .exec_wr_data(exec_wr_data[g]),
      .exec_gnt(exec_gnt[g]), .exec_rd_valid(exec_rd_valid[g]), .exec_rd_data(exec_rd_data[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end

  function automatic logic [54:0] outs(int g);
    return {ifu_gnt[g], ifu_rd_valid[g], ifu_rd_data[g], exec_gnt[g], exec_rd_valid[g], exec_rd_data[g],
            mem_req[g], mem_we[g], mem_addr[g], mem_wdata[g], busy[g]};
  endfunction

  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    if (reset_n) begin
      if (ifu_gnt[0] || exec_gnt[0]) begin
        checks++;
        if ((ifu_gnt[0] && exec_gnt[0]) || ifu_rd_valid[0] || exec_rd_valid[0]) begin
          errors++;
          $display("FAIL gnt_exclusive cyc %0d ifu_gnt %b exec_gnt %b valids %b%b", cyc, ifu_gnt[0], exec_gnt[0], ifu_rd_valid[0], exec_rd_valid[0]);
        end
        glog.push_back(int'(exec_gnt[0]));
      end
      if (ifu_rd_valid[0]) begin
        checks++;
        if (ifu_q.size() == 0) begin
          errors++;
          $display("FAIL ifu_unexpected_valid cyc %0d data %o", cyc, ifu_rd_data[0]);
        end else begin
          e = ifu_q.pop_front();
          if (ifu_rd_data[0] !== e) begin
            errors++;
            $display("FAIL ifu_rd_data got %o want %o", ifu_rd_data[0], e);
          end
        end
      end
      if (exec_rd_valid[0]) begin
        checks++;
        if (exec_q.size() == 0) begin
          errors++;
          $display("FAIL exec_unexpected_valid cyc %0d data %o", cyc, exec_rd_data[0]);
        end else begin
          e = exec_q.pop_front();
          if (exec_rd_data[0] !== e) begin
            errors++;
            $display("FAIL exec_rd_data got %o want %o", exec_rd_data[0], e);
          end
        end
      end
    end
  endtask

  task automatic raise(int i, int k, logic [11:0] a, logic [11:0] d);
    case (k)
      0: begin ifu_rd_req[i] = 1'b1; ifu_rd_addr[i] = a; end
      1: begin exec_rd_req[i] = 1'b1; exec_rd_addr[i] = a; end
      default: begin exec_wr_req[i] = 1'b1; exec_wr_addr[i] = a; exec_wr_data[i] = d; end
    endcase
  endtask

  task automatic wait_gnt(int i, int k, output int c);
    bit got;
    got = 1'b0;
    c = -1;
    for (int n = 0; n < 60 && !got; n++) begin
      tick();
      if (ifu_gnt[i]) begin
        ifu_rd_req[i] = 1'b0;
        got = k == 0;
      end
      if (exec_gnt[i]) begin
        if (exec_wr_req[i]) begin
          exec_wr_req[i] = 1'b0;
          got = got || k == 2;
        end else begin
          exec_rd_req[i] = 1'b0;
          got = got || k == 1;
        end
      end
      if (got) c = cyc;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout inst %0d kind %0d got none want gnt", i, k);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (ifu_q.size() != 0 || exec_q.size() != 0); n++) tick();
    checks++;
    if (ifu_q.size() != 0 || exec_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending ifu %0d exec %0d want 0", ifu_q.size(), exec_q.size());
    end
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (outs(g) !== 55'd0) begin
        errors++;
        $display("FAIL reset_outs inst %0d got %h want 0", g, outs(g));
      end
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy[0] !== 1'b0 || mem_req[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy %b mem_req %b want 0 0", busy[0], mem_req[0]);
    end
  endtask

  task automatic test_write_read();
    int r, c, v;
    r = cyc;
    raise(0, 2, 12'o0100, 12'o1234);
    wait_gnt(0, 2, c);
    checks++;
    if (c - r != 1) begin
      errors++;
      $display("FAIL wr_gnt_latency got %0d want 1", c - r);
    end
    tick();
    r = cyc;
    raise(0, 1, 12'o0100, 12'o0);
    exec_q.push_back(12'o1234);
    wait_gnt(0, 1, c);
    checks++;
    if (c - r != 1) begin
      errors++;
      $display("FAIL rd_gnt_latency got %0d want 1", c - r);
    end
    v = -1;
    for (int n = 0; n < 20 && v < 0; n++) begin
      tick();
      if (exec_rd_valid[0]) v = cyc;
    end
    checks++;
    if (v - r != 3) begin
      errors++;
      $display("FAIL rd_valid_latency got %0d want 3", v - r);
    end
  endtask

  task automatic test_collision();
    int r, c1, c2;
    reset_pulse();
    glog.delete();
    r = cyc;
    raise(0, 0, 12'o0200, 12'o0);
    raise(0, 1, 12'o0300, 12'o0);
    ifu_q.push_back(12'o7577);
    exec_q.push_back(12'o7477);
    wait_gnt(0, 1, c1);
    wait_gnt(0, 0, c2);
    checks++;
    if (c1 - r != 1 || c2 - c1 != 4) begin
      errors++;
      $display("FAIL collision_timing got exec +%0d ifu +%0d want +1 +4", c1 - r, c2 - c1);
    end
    checks++;
    if (glog.size() < 2 || glog[0] != 1 || glog[1] != 0) begin
      errors++;
      $display("FAIL collision_order got %p want exec then ifu", glog);
    end
    drain();
  endtask

  task automatic test_illegal();
    int c1, c2;
    raise(0, 2, 12'o0050, 12'o0005);
    raise(0, 1, 12'o0050, 12'o0);
    exec_q.push_back(12'o0005);
    wait_gnt(0, 2, c1);
    wait_gnt(0, 1, c2);
    checks++;
    if (c2 - c1 != 2) begin
      errors++;
      $display("FAIL illegal_wr_then_rd got %0d want 2", c2 - c1);
    end
    drain();
  endtask

  task automatic test_reset_mid_read();
    int c, seen;
    raise(0, 0, 12'o0200, 12'o0);
    wait_gnt(0, 0, c);
    @(posedge clk);
    #2;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_busy got %b want 1", busy[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs(0) !== 55'd0) begin
      errors++;
      $display("FAIL mid_read_reset_outs got %h want 0", outs(0));
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (ifu_rd_valid[0]) seen++;
    end
    checks++;
    if (seen != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_dropped valids %0d busy %b want 0 0", seen, busy[0]);
    end
  endtask

  task automatic test_stream();
    int exp_cls, got_cls;
    bit seen;
    reset_pulse();
    raise(0, 1, 12'o0310, 12'o0);
    exec_q.push_back(12'o7467);
    raise(0, 0, 12'o0210, 12'o0);
    ifu_q.push_back(12'o7567);
    for (int t = 0; t < 6; t++) begin
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        tick();
        seen = ifu_gnt[0] || exec_gnt[0];
      end
      got_cls = int'(exec_gnt[0]);
      exp_cls = RR ? (t % 2 == 0 ? 1 : 0) : 1;
      checks++;
      if (!seen || got_cls != exp_cls) begin
        errors++;
        $display("FAIL stream_grant %0d got %0d want %0d (1=exec 0=ifu)", t, seen ? got_cls : -1, exp_cls);
      end
      if (t < 5) begin
        if (got_cls == 1) exec_q.push_back(12'o7467);
        else ifu_q.push_back(12'o7567);
      end else begin
        ifu_rd_req[0] = 1'b0;
        exec_rd_req[0] = 1'b0;
        if (got_cls == 1) void'(ifu_q.pop_back());
        else void'(exec_q.pop_back());
      end
    end
    drain();
  endtask

  task automatic test_latency_sweep();
    int c, v;
    for (int g = 0; g < 3; g++) begin
      raise(g, 2, 12'o0400, 12'o7777);
      wait_gnt(g, 2, c);
      tick();
      raise(g, 0, 12'o0400, 12'o0);
      if (g == 0) ifu_q.push_back(12'o7777);
      wait_gnt(g, 0, c);
      v = -1;
      for (int n = 0; n < 20 && v < 0; n++) begin
        tick();
        if (ifu_rd_valid[g]) v = cyc;
      end
      checks++;
      if (v < 0 || v - c != lat_of(g) + 1) begin
        errors++;
        $display("FAIL sweep_latency lat %0d got %0d want %0d", lat_of(g), v < 0 ? -1 : v - c, lat_of(g) + 1);
      end
      checks++;
      if (ifu_rd_data[g] !== 12'o7777) begin
        errors++;
        $display("FAIL sweep_data lat %0d got %o want 7777", lat_of(g), ifu_rd_data[g]);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ifu_rd_req[i] = 1'b0;
      ifu_rd_addr[i] = 12'o0;
      exec_rd_req[i] = 1'b0;
      exec_rd_addr[i] = 12'o0;
      exec_wr_req[i] = 1'b0;
      exec_wr_addr[i] = 12'o0;
      exec_wr_data[i] = 12'o0;
    end
    test_reset();
    test_write_read();
    test_collision();
    test_illegal();
    test_reset_mid_read();
    test_stream();
    test_latency_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
